cache_mem_responder: RTL and testbench

- Memory-side responder for the cache/internal-memory-controller interface; the opposite end of a cache's req/rw/add/write/read/ready handshakes.
- Accepts single-word or full-block requests from one cache, buffers block data, and moves it to and from a simple word-wide backing-memory port.
- Sits between a cache instance and the external memory arbiter. One outstanding cache request at a time.

---
 rtl/cache_mem_responder_pkg.sv | 17 +
 rtl/cache_mem_responder_if.sv | 42 ++++
 rtl/cache_mem_block_buffer.sv | 44 ++++
 rtl/cache_mem_responder.sv | 137 +++++++++++++
 tb/tb_cache_mem_responder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_responder_pkg.sv
// Shared types and default geometry for the cache-side memory responder.
// State encoding is fixed so it reads the same in waveforms and in the bench.
package cache_mem_responder_pkg;

  localparam int unsigned BW_WORD_ADDR = 16;
  localparam int unsigned BW_BLOCK     = 4;
  localparam int unsigned BLOCK_WORDS  = 2 ** BW_BLOCK;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWrFill   = 3'd1,
    StWrCommit = 3'd2,
    StRdFetch  = 3'd3,
    StRdDrain  = 3'd4
  } state_e;

endpackage

// File: rtl/cache_mem_responder_if.sv
// Cache-side handshakes and the word-wide backing-memory port of the responder.
// Signal suffixes are from the responder's point of view.
interface cache_mem_responder_if
  import cache_mem_responder_pkg::*;
#(
  parameter int unsigned BW_ADDR = BW_WORD_ADDR
);

  logic               cache_en_o;
  logic               req_i;
  logic               req_block_i;
  logic               rw_i;
  logic [BW_ADDR-1:0] add_i;
  logic               ready_req_o;
  logic               write_i;
  logic [31:0]        data_i;
  logic               ready_write_o;
  logic               read_i;
  logic [31:0]        data_o;
  logic               ready_read_o;
  logic               mem_req_o;
  logic               mem_rw_o;
  logic [BW_ADDR-1:0] mem_addr_o;
  logic [31:0]        mem_data_o;
  logic               mem_ack_i;
  logic [31:0]        mem_data_i;

  modport slave (
    output cache_en_o, ready_req_o, ready_write_o, data_o, ready_read_o,
    output mem_req_o, mem_rw_o, mem_addr_o, mem_data_o,
    input  req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
    input  mem_ack_i, mem_data_i
  );

  modport master (
    input  cache_en_o, ready_req_o, ready_write_o, data_o, ready_read_o,
    input  mem_req_o, mem_rw_o, mem_addr_o, mem_data_o,
    output req_i, req_block_i, rw_i, add_i, write_i, data_i, read_i,
    output mem_ack_i, mem_data_i
  );

endinterface

// File: rtl/cache_mem_block_buffer.sv
// Block-sized word buffer: one write port and one registered read port.
// A same-cycle write to the word being read is forwarded into the read register.
module cache_mem_block_buffer #(
  parameter int unsigned BW_BLK = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [BW_BLK-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [BW_BLK-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Words = 2 ** BW_BLK;

  logic [31:0] mem_q [Words];
  logic [31:0] mem_d [Words];
  logic [31:0] rdata_q, rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
    rdata_d = mem_d[raddr_i];
  end

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clock_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for one cache: captures a word/block request, buffers the
// data and moves it word by word to or from the backing memory.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int unsigned BW_ADDR  = BW_WORD_ADDR,
  parameter int unsigned BW_BLK   = BW_BLOCK,
  parameter int unsigned EN_DELAY = 4
) (
  input logic                  clock_i,
  input logic                  reset_i,
  cache_mem_responder_if.slave bus
);

  localparam int unsigned        CntW    = BW_BLK + 1;
  localparam int unsigned        EnW     = (EN_DELAY > 2) ? $clog2(EN_DELAY) : 1;
  localparam logic [CntW-1:0]    LastBlk = CntW'(2 ** BW_BLK - 1);
  localparam logic [EnW-1:0]     EnLast  = EnW'(EN_DELAY - 1);
  localparam logic [BW_ADDR-1:0] BlkMask = BW_ADDR'(2 ** BW_BLK - 1);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [BW_ADDR-1:0] base_q, base_d;
  logic               block_q, block_d;
  logic [EnW-1:0]     en_cnt_q, en_cnt_d;
  logic               cache_en_q, cache_en_d;

  logic        ready_req, last, buf_we;
  logic [31:0] buf_wdata, buf_rdata;

  always_comb begin
    en_cnt_d   = en_cnt_q;
    cache_en_d = cache_en_q;
    if (!cache_en_q) begin
      if (en_cnt_q == EnLast) begin
        cache_en_d = 1'b1;
      end else begin
        en_cnt_d = en_cnt_q + 1'b1;
      end
    end
  end

  assign ready_req = (state_q == StIdle) && cache_en_q;
  // One counter serves fill, commit, fetch and drain; the phases never overlap.
  assign last      = block_q ? (cnt_q == LastBlk) : (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    block_d = block_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_i && ready_req) begin
          block_d = bus.req_block_i;
          base_d  = bus.req_block_i ? (bus.add_i & ~BlkMask) : bus.add_i;
          cnt_d   = '0;
          state_d = bus.rw_i ? StWrFill : StRdFetch;
        end
      end
      StWrFill: begin
        if (bus.write_i) begin
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? StWrCommit : StWrFill;
        end
      end
      StWrCommit: begin
        if (bus.mem_ack_i) begin
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? StIdle : StWrCommit;
        end
      end
      StRdFetch: begin
        if (bus.mem_ack_i) begin
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? StRdDrain : StRdFetch;
        end
      end
      StRdDrain: begin
        if (bus.read_i) begin
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? StIdle : StRdDrain;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      base_q     <= '0;
      block_q    <= 1'b0;
      en_cnt_q   <= '0;
      cache_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      block_q    <= block_d;
      en_cnt_q   <= en_cnt_d;
      cache_en_q <= cache_en_d;
    end
  end

  assign buf_we    = ((state_q == StWrFill) && bus.write_i) ||
                     ((state_q == StRdFetch) && bus.mem_ack_i);
  assign buf_wdata = (state_q == StWrFill) ? bus.data_i : bus.mem_data_i;

  // Read index is the next count, so the registered head is ready when it is needed.
  cache_mem_block_buffer #(
    .BW_BLK (BW_BLK)
  ) u_buffer (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .we_i    (buf_we),
    .waddr_i (cnt_q[BW_BLK-1:0]),
    .wdata_i (buf_wdata),
    .raddr_i (cnt_d[BW_BLK-1:0]),
    .rdata_o (buf_rdata)
  );

  assign bus.cache_en_o    = cache_en_q;
  assign bus.ready_req_o   = ready_req;
  assign bus.ready_write_o = (state_q == StWrFill);
  assign bus.ready_read_o  = (state_q == StRdDrain);
  assign bus.data_o        = (state_q == StRdDrain) ? buf_rdata : '0;
  assign bus.mem_req_o     = (state_q == StWrCommit) || (state_q == StRdFetch);
  assign bus.mem_rw_o      = (state_q == StWrCommit);
  assign bus.mem_addr_o    = bus.mem_req_o ? (base_q + BW_ADDR'(cnt_q)) : '0;
  assign bus.mem_data_o    = (state_q == StWrCommit) ? buf_rdata : '0;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: expected memory accesses and cache pops
// are queued when a request is issued and checked as the DUT produces them.
module tb_cache_mem_responder;
  import cache_mem_responder_pkg::*;

  localparam int unsigned AW      = BW_WORD_ADDR;
  localparam int unsigned NBLK    = BLOCK_WORDS;
  localparam int unsigned EnDelay = 4;

  logic clock_i = 1'b0;
  logic reset_i = 1'b1;

  cache_mem_responder_if #(.BW_ADDR(AW)) bus ();

  cache_mem_responder #(
    .BW_ADDR  (AW),
    .BW_BLK   (BW_BLOCK),
    .EN_DELAY (EnDelay)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clock_i = ~clock_i;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } mem_acc_t;

  mem_acc_t    exp_mem_q[$];
  logic [31:0] exp_pop_q[$];
  mem_acc_t    mon_acc;
  logic [31:0] mon_pop;

  // Backing-memory model: ack every ack_period cycles, read data = address or constant.
  int unsigned ack_period    = 1;
  int unsigned cyc           = 0;
  logic        data_const_en = 1'b0;
  logic [31:0] data_const    = '0;

  initial begin
    bus.mem_ack_i = 1'b0;
    forever begin
      @(posedge clock_i);
      #1;
      cyc++;
      bus.mem_ack_i = ((cyc % ack_period) == 0);
    end
  end

  always_comb bus.mem_data_i = data_const_en ? data_const : 32'(bus.mem_addr_o);

  always @(negedge clock_i) begin
    if (!reset_i) begin
      if (bus.mem_req_o) check_eq("ready_req_while_busy", 64'(bus.ready_req_o), 64'd0);
      if (bus.mem_req_o && bus.mem_ack_i) begin
        if (exp_mem_q.size() == 0) begin
          check_eq("mem_extra_access", 64'(exp_mem_q.size()), 64'd1);
        end else begin
          mon_acc = exp_mem_q.pop_front();
          check_eq("mem_rw", 64'(bus.mem_rw_o), 64'(mon_acc.rw));
          check_eq("mem_addr", 64'(bus.mem_addr_o), 64'(mon_acc.addr));
          if (mon_acc.rw) check_eq("mem_wdata", 64'(bus.mem_data_o), 64'(mon_acc.data));
        end
      end
      if (bus.ready_read_o && bus.read_i) begin
        if (exp_pop_q.size() == 0) begin
          check_eq("pop_extra", 64'(exp_pop_q.size()), 64'd1);
        end else begin
          mon_pop = exp_pop_q.pop_front();
          check_eq("pop_data", 64'(bus.data_o), 64'(mon_pop));
        end
      end
    end
  end

  function automatic logic quiet_outs();
    return |{bus.ready_write_o, bus.ready_read_o, bus.mem_req_o, bus.mem_rw_o,
             bus.mem_addr_o, bus.mem_data_o, bus.data_o};
  endfunction

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic request(input logic blk, input logic rw, input logic [AW-1:0] addr);
    int k = 0;
    while (!bus.ready_req_o && k < 100) begin
      step();
      k++;
    end
    check_eq("req_ready", 64'(bus.ready_req_o), 64'd1);
    bus.req_i       = 1'b1;
    bus.req_block_i = blk;
    bus.rw_i        = rw;
    bus.add_i       = addr;
    step();
    bus.req_i = 1'b0;
  endtask

  task automatic wait_read_ready(input string tag, input int exp_lat);
    int lat = 0;
    while (!bus.ready_read_o && lat < 400) begin
      step();
      lat++;
    end
    check_eq(tag, 64'(lat), 64'(exp_lat));
  endtask

  // Pops until ready_read_o drops; at stray_at a write strobe replaces the pop.
  task automatic drain(input int stray_at);
    int k = 0;
    while (bus.ready_read_o && k < 100) begin
      if (k == stray_at) begin
        bus.write_i = 1'b1;
        bus.data_i  = 32'h5555_5555;
        bus.read_i  = 1'b0;
      end else begin
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
      end
      step();
      k++;
    end
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
    check_eq("drain_done_ready_read", 64'(bus.ready_read_o), 64'd0);
    check_eq("drain_done_ready_req", 64'(bus.ready_req_o), 64'd1);
    check_eq("drain_pops_left", 64'(exp_pop_q.size()), 64'd0);
    check_eq("drain_mem_left", 64'(exp_mem_q.size()), 64'd0);
  endtask

  task automatic expect_block_read(input logic [AW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_mem_q.push_back('{rw: 1'b0, addr: base + AW'(i), data: '0});
      exp_pop_q.push_back(32'(base + AW'(i)));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int nw;
    bus.req_i       = 1'b0;
    bus.req_block_i = 1'b0;
    bus.rw_i        = 1'b0;
    bus.add_i       = '0;
    bus.write_i     = 1'b0;
    bus.data_i      = '0;
    bus.read_i      = 1'b0;

    // Reset and enable delay
    step();
    step();
    check_eq("rst_cache_en", 64'(bus.cache_en_o), 64'd0);
    check_eq("rst_ready_req", 64'(bus.ready_req_o), 64'd0);
    check_eq("rst_quiet", 64'(quiet_outs()), 64'd0);
    reset_i = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      step();
      check_eq($sformatf("cache_en_c%0d", c), 64'(bus.cache_en_o), 64'(c >= int'(EnDelay)));
      check_eq($sformatf("ready_req_c%0d", c), 64'(bus.ready_req_o), 64'(c >= int'(EnDelay)));
      check_eq($sformatf("quiet_c%0d", c), 64'(quiet_outs()), 64'd0);
    end

    // Block read, ack tied high; a stray write lands mid-drain
    ack_period = 1;
    expect_block_read(16'h1230, int'(NBLK));
    request(1'b1, 1'b0, 16'h1237);
    wait_read_ready("blk_rd_latency", int'(NBLK));
    drain(5);

    // Block write, ack every 3rd cycle; stray read during fill, stray req during commit
    ack_period = 3;
    for (int i = 0; i < int'(NBLK); i++) begin
      exp_mem_q.push_back('{rw: 1'b1, addr: 16'h0040 + AW'(i), data: 32'hA0 + 32'(i)});
    end
    request(1'b1, 1'b1, 16'h0040);
    nw = 0;
    k  = 0;
    while (nw < int'(NBLK) && k < 100) begin
      if (k == 3) begin
        bus.write_i = 1'b0;
        bus.read_i  = 1'b1;
      end else begin
        bus.write_i = 1'b1;
        bus.read_i  = 1'b0;
        bus.data_i  = 32'hA0 + 32'(nw);
      end
      step();
      if (bus.write_i) nw++;
      k++;
    end
    bus.write_i = 1'b0;
    bus.read_i  = 1'b0;
    check_eq("wr_ready_write_drop", 64'(bus.ready_write_o), 64'd0);
    check_eq("wr_commit_started", 64'(bus.mem_req_o), 64'd1);
    k = 0;
    while (!bus.ready_req_o && k < 300) begin
      bus.req_i = (k < 2);
      step();
      k++;
    end
    bus.req_i = 1'b0;
    check_eq("wr_mem_left", 64'(exp_mem_q.size()), 64'd0);
    step();
    check_eq("wr_idle_no_capture", 64'(bus.ready_req_o), 64'd1);
    check_eq("wr_idle_no_mem_req", 64'(bus.mem_req_o), 64'd0);

    // Single-word read
    ack_period    = 1;
    data_const_en = 1'b1;
    data_const    = 32'hDEAD_BEEF;
    exp_mem_q.push_back('{rw: 1'b0, addr: 16'h0005, data: '0});
    exp_pop_q.push_back(32'hDEAD_BEEF);
    request(1'b0, 1'b0, 16'h0005);
    wait_read_ready("word_rd_latency", 1);
    drain(-1);
    data_const_en = 1'b0;

    // Reset during a fetch, then a fresh read
    expect_block_read(16'h0100, int'(NBLK));
    request(1'b1, 1'b0, 16'h0105);
    repeat (7) step();
    reset_i = 1'b1;
    #1;
    check_eq("abort_acks_seen", 64'(int'(NBLK) - exp_mem_q.size()), 64'd7);
    check_eq("abort_quiet", 64'(quiet_outs()), 64'd0);
    check_eq("abort_cache_en", 64'(bus.cache_en_o), 64'd0);
    check_eq("abort_ready_req", 64'(bus.ready_req_o), 64'd0);
    exp_mem_q.delete();
    exp_pop_q.delete();
    step();
    reset_i = 1'b0;
    expect_block_read(16'h2340, int'(NBLK));
    request(1'b1, 1'b0, 16'h234B);
    wait_read_ready("post_rst_latency", int'(NBLK));
    drain(-1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
